// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory arbiter
//
// Contents:
//   arb_state_t     : arbiter FSM states IDLE / ACCESS / RESP
//   grant_t         : which requester owns the current access
//   WAIT_CYCLES_MAX : largest supported wait-state count
//   cnt_width()     : wait-counter width, never narrower than one bit

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

    localparam int WAIT_CYCLES_MAX = 15;

    // $clog2(1) is 0, so a zero wait count still needs a one-bit counter.
    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant selection between fetch and data requesters
//
// Build option: MEM_ARB_RR_EN selects round-robin on contention; otherwise
// fixed data-first priority with no last-grant state.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset (round-robin state only)
//   take       : a grant is being accepted this cycle
//   if_req     : fetch request
//   d_req      : data request
//   any_req    : at least one request is pending
//   gnt_d      : 1 = data port wins, 0 = fetch port wins

module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic take,
    input  logic if_req,
    input  logic d_req,
    output logic any_req,
    output logic gnt_d
);

    assign any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
    grant_t last_grant;

    // Starts at fetch so the very first contended grant goes to data.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GNT_IF;
        end else if (take) begin
            last_grant <= gnt_d ? GNT_D : GNT_IF;
        end
    end

    always_comb begin
        gnt_d = 1'b0;
        if (if_req && d_req) begin
            gnt_d = (last_grant == GNT_IF);
        end else begin
            gnt_d = d_req;
        end
    end
`else
    // The MEM-stage access is older than the fetch, so data always wins.
    logic unused_rr_inputs;
    assign unused_rr_inputs = ^{clk, reset, take};

    always_comb begin
        gnt_d = d_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port unified memory shared by fetch and data ports
//
// Build option: MEM_ARB_RR_EN (round-robin on contention, see mem_arb_pick).
//
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   if_req/if_addr            : fetch request, held until if_ready
//   if_rdata/if_ready         : fetched word and one-cycle completion pulse
//   d_req/d_we/d_sb/d_addr/d_wdata : data request (load/store/byte store)
//   d_rdata/d_ready           : load data and one-cycle completion pulse
//   mem_en/mem_we/mem_sb      : memory enable, write strobe, byte-store qualifier
//   mem_addr/mem_wdata        : latched address and store data
//   mem_rdata                 : combinational read data from memory

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_sb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_sb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Out-of-range wait counts are clamped to the supported maximum.
    localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX :
                              (WAIT_CYCLES < 0) ? 0 : WAIT_CYCLES;
    localparam int CNT_W = cnt_width(WAIT_EFF);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF);

    arb_state_t        state;
    arb_state_t        state_nxt;
    grant_t            grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic              sb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              any_req;
    logic              pick_d;
    logic              take;
    logic              last_access;

    mem_arb_pick u_pick (
        .clk     (clk),
        .reset   (reset),
        .take    (take),
        .if_req  (if_req),
        .d_req   (d_req),
        .any_req (any_req),
        .gnt_d   (pick_d)
    );

    // The final ACCESS cycle: store strobe and read capture both happen here.
    assign last_access = (state == ACCESS) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= GNT_IF;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            sb_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        // Everything the access needs is frozen here, so a
                        // requester misbehaving mid-access cannot corrupt it.
                        grant_q <= pick_d ? GNT_D : GNT_IF;
                        addr_q  <= pick_d ? d_addr : if_addr;
                        we_q    <= pick_d & d_we;
                        sb_q    <= pick_d & d_we & d_sb;
                        wdata_q <= pick_d ? d_wdata : '0;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (grant_q == GNT_D) begin
                        d_rdata <= mem_rdata;
                    end else begin
                        if_rdata <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_sb    = 1'b0;
        if_ready  = 1'b0;
        d_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_sb = sb_q;
                if (last_access) begin
                    mem_we    = we_q;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if_ready  = (grant_q == GNT_IF);
                d_ready   = (grant_q == GNT_D);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
